k6502_bus_responder: RTL and testbench
======================================

// Module: k6502_bus_responder
// PURPOSE
// Memory-mapped RAM target on the external 6502 bus. It is the responder end of the bus that the k6502 core drives.
// It decodes a[15:0] against a base window and serves read cycles (optional wait states via rdy). It captures writes at
// the end of phase 2. Runs on ph0; the bus phase is seen as the phi2 level sampled on each ph0 rising edge.
// PARAMETERS
// BASE_ADDR    16'h0000  first byte address of the window; must be aligned to 2**ADDR_BITS
// ADDR_BITS    11        window/RAM size = 2**ADDR_BITS bytes (2 KiB default); BASE_ADDR+2**ADDR_BITS <= 17'h10000
// WAIT_STATES  0         extra ph0 cycles rdy is held low on a read hit (0..15)
// PORTS
// ph0        in   1   clock; all state updates on rising edge
// reset_n    in   1   synchronous active-low reset, sampled on ph0 rising edge
// phi2       in   1   bus phase 2 level from clockgen (ph2_out)
// a          in   16  CPU address bus
// rw         in   1   1 = read, 0 = write
// d_in       in   8   CPU data bus (write data)
// d_out      out  8   read data; top level tristates d with d_oe
// d_oe       out  1   drive enable for d_out onto d
// rdy        out  1   0 = stretch current read cycle
// sel        out  1   registered: current bus cycle hits the window
// overrun    out  1   one-cycle pulse: phi2 fell before read data was ready
// BEHAVIOUR
// - Reset (reset_n=0 at edge): state=IDLE, d_out=8'h00, d_oe=0, rdy=1, sel=0, overrun=0, wait counter=0.
//   No RAM write occurs on a reset edge. RAM contents are not reset.
// - phi2_q = phi2 registered. rise = phi2 & ~phi2_q, fall = ~phi2 & phi2_q.
// - hit = (a[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]). Evaluated only at rise; a, rw latched into addr_q, rw_q at rise.
// - States: IDLE, READ_WAIT, DRIVE, WRITE.
//   IDLE: rise & hit & rw -> READ_WAIT, cnt<=WAIT_STATES, sel<=1, RAM read issued at a[ADDR_BITS-1:0] (ram_q valid next cycle).
//         rise & hit & ~rw -> WRITE, sel<=1. rise & ~hit -> stay IDLE, sel<=0.
//   READ_WAIT: cnt==0 -> d_out<=ram_q, DRIVE; else cnt<=cnt-1. fall in READ_WAIT -> IDLE, overrun=1 for one cycle, d_oe stays 0.
//   DRIVE: d_oe=1. fall -> IDLE, d_oe=0 from that edge.
//   WRITE: fall -> RAM[addr_q]<=d_in as sampled at that edge (data valid late phase 2), -> IDLE. One write per cycle.
// - Latency, rise sampled at edge N: d_oe high after edge N+1+WAIT_STATES.
//   rdy = ~(state==READ_WAIT && cnt!=0): low after N through edge N+WAIT_STATES. WAIT_STATES=0 never drops rdy.
// - d_oe is asserted only in DRIVE. Never in IDLE/WRITE and never during reset.
// - A rise while not in IDLE (malformed bus) is ignored. rise and fall on the same edge cannot happen (phi2_q is 1 bit).
// - rw/a changing after rise is ignored until the next rise. sel clears on the IDLE transition.
// - Boundaries: BASE_ADDR+2**ADDR_BITS-1 hits; BASE_ADDR-1 and BASE_ADDR+2**ADDR_BITS miss.
//   RAM index is a[ADDR_BITS-1:0], with no wrap inside the window.
// - Reset asserted in any state aborts the cycle: pending write dropped, d_oe=0 on that edge.
// STRUCTURE
// - k6502_bus_pkg: typedef enum logic [1:0] bus_resp_state_t {IDLE, READ_WAIT, DRIVE, WRITE};
//   localparam RW_READ=1'b1; localparam WAIT_CNT_BITS=4.
// - Sub-module bus_ram_sp: single-port sync RAM, 2**ADDR_BITS x 8, registered read (1 cycle), write enable. No reset on array.
// - FSM, counter, phi2 edge detect and decode live in this module.
// TESTING
// 1 reset: hold reset_n=0 for 3 edges mid-DRIVE -> d_oe=0, rdy=1, sel=0, state IDLE on first reset edge.
// 2 write then read, WAIT_STATES=0: write 8'hA5 at 16'h0123, then read 16'h0123 -> d_out=8'hA5, d_oe high after N+1, rdy stays 1.
// 3 WAIT_STATES=3: read 16'h07FF after writing 8'h3C -> rdy low 3 cycles, d_oe high after N+4, d_out=8'h3C.
// 4 decode: BASE_ADDR=16'h0800: write 8'h11 to 16'h07FF and 16'h1000 -> sel=0, d_oe never 1; read 16'h0800 returns prior contents.
// 5 overrun: WAIT_STATES=5, drop phi2 after 2 cycles -> overrun one-cycle pulse, d_oe stays 0, next read works normally.
// 6 write abort: reset_n=0 in WRITE before fall -> RAM location keeps old value (8'h5A verified by later read).

Source files
------------

// File: rtl/k6502_bus_responder_pkg.sv
// Shared types and constants for the 6502 bus RAM responder.
// Both the responder top and the testbench import this package.
package k6502_bus_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      DRIVE     = 2'd2,
      WRITE     = 2'd3
   } bus_resp_state_t;

   localparam logic RW_READ       = 1'b1;
   localparam int   WAIT_CNT_BITS = 4;

   // Window decode: the address bits above the RAM index must match the base.
   function automatic logic window_hit(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input int          abits);
      return (addr >> abits) == (base >> abits);
   endfunction

endpackage

// File: rtl/k6502_bus_responder_if.sv
// 6502 external bus as seen by a memory-mapped responder.
// The master modport is the CPU side; the slave modport is the RAM target.
interface k6502_bus_responder_if;
   logic        phi2;
   logic [15:0] a;
   logic        rw;
   logic [7:0]  d_in;
   logic [7:0]  d_out;
   logic        d_oe;
   logic        rdy;
   logic        sel;
   logic        overrun;

   modport master (
      output phi2, a, rw, d_in,
      input  d_out, d_oe, rdy, sel, overrun
   );

   modport slave (
      input  phi2, a, rw, d_in,
      output d_out, d_oe, rdy, sel, overrun
   );
endinterface

// File: rtl/k6502_bus_responder_ram.sv
// Single-port synchronous RAM with one-cycle registered read.
// The array is deliberately not reset so it maps onto block RAM.
module bus_ram_sp #(
   parameter int ADDR_BITS = 11
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata
);

   logic [7:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/k6502_bus_responder.sv
// RAM responder on the 6502 external bus: decodes a window, serves reads with
// optional rdy wait states and captures writes at the falling edge of phi2.
//
// state     | meaning
// IDLE      | waiting for a phi2 rise that hits the window
// READ_WAIT | read accepted, counting wait states while rdy is held low
// DRIVE     | read data on d_out with d_oe high until phi2 falls
// WRITE     | write accepted, data captured into RAM when phi2 falls
module k6502_bus_responder
   import k6502_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          ADDR_BITS   = 11,
   parameter int          WAIT_STATES = 0
) (
   input  logic                  ph0,
   input  logic                  reset_n,
   k6502_bus_responder_if.slave  bus
);

   localparam logic [WAIT_CNT_BITS-1:0] WAIT_INIT = WAIT_CNT_BITS'(WAIT_STATES);

   bus_resp_state_t          state;
   logic                     phi2_q;
   logic [WAIT_CNT_BITS-1:0] cnt;
   logic [ADDR_BITS-1:0]     addr_q;
   logic                     rw_q;
   logic [7:0]               d_out_r;
   logic                     d_oe_r;
   logic                     rdy_r;
   logic                     sel_r;
   logic                     overrun_r;

   logic                     rise;
   logic                     fall;
   logic                     hit;
   logic                     ram_we;
   logic                     ram_re;
   logic [ADDR_BITS-1:0]     ram_addr;
   logic [7:0]               ram_q;

   assign rise = bus.phi2 & ~phi2_q;
   assign fall = ~bus.phi2 & phi2_q;
   assign hit  = window_hit(bus.a, BASE_ADDR, ADDR_BITS);

   // A write commits only on a non-reset fall edge, so reset drops a pending write.
   assign ram_we   = reset_n && (state == WRITE) && fall && (rw_q != RW_READ);
   assign ram_re   = reset_n && (state == IDLE) && rise && hit && (bus.rw == RW_READ);
   assign ram_addr = (state == WRITE) ? addr_q : bus.a[ADDR_BITS-1:0];

   bus_ram_sp #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk   (ph0),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (bus.d_in),
      .rdata (ram_q)
   );

   always_ff @(posedge ph0) begin
      if (!reset_n) begin
         // Track phi2 through reset so a level held across release is not a rise.
         phi2_q    <= bus.phi2;
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         rw_q      <= RW_READ;
         d_out_r   <= 8'h00;
         d_oe_r    <= 1'b0;
         rdy_r     <= 1'b1;
         sel_r     <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         phi2_q    <= bus.phi2;
         overrun_r <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  addr_q <= bus.a[ADDR_BITS-1:0];
                  rw_q   <= bus.rw;
                  if (hit) begin
                     sel_r <= 1'b1;
                     if (bus.rw == RW_READ) begin
                        state <= READ_WAIT;
                        cnt   <= WAIT_INIT;
                        rdy_r <= (WAIT_INIT == '0);
                     end else begin
                        state <= WRITE;
                     end
                  end else begin
                     sel_r <= 1'b0;
                  end
               end
            end
            READ_WAIT: begin
               if (fall) begin
                  state     <= IDLE;
                  sel_r     <= 1'b0;
                  rdy_r     <= 1'b1;
                  cnt       <= '0;
                  overrun_r <= 1'b1;
               end else if (cnt == '0) begin
                  state   <= DRIVE;
                  d_out_r <= ram_q;
                  d_oe_r  <= 1'b1;
               end else begin
                  cnt   <= cnt - 1'b1;
                  rdy_r <= (cnt == WAIT_CNT_BITS'(1));
               end
            end
            DRIVE: begin
               if (fall) begin
                  state  <= IDLE;
                  d_oe_r <= 1'b0;
                  sel_r  <= 1'b0;
               end
            end
            WRITE: begin
               if (fall) begin
                  state <= IDLE;
                  sel_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.d_out   = d_out_r;
   assign bus.d_oe    = d_oe_r;
   assign bus.rdy     = rdy_r;
   assign bus.sel     = sel_r;
   assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_k6502_bus_responder.sv
// Directed bench for the bus responder: three instances share one bus stimulus
// (base 0 / 0 waits, base 0 / 3 waits, base 0x0800 / 5 waits).
module tb_k6502_bus_responder;
   import k6502_bus_pkg::*;

   logic        ph0;
   logic        reset_n;
   logic        phi2;
   logic [15:0] a;
   logic        rw;
   logic [7:0]  d_in;

   int errors = 0;
   int checks = 0;

   k6502_bus_responder_if bus0 ();
   k6502_bus_responder_if bus3 ();
   k6502_bus_responder_if bus8 ();

   assign bus0.phi2 = phi2;
   assign bus0.a    = a;
   assign bus0.rw   = rw;
   assign bus0.d_in = d_in;
   assign bus3.phi2 = phi2;
   assign bus3.a    = a;
   assign bus3.rw   = rw;
   assign bus3.d_in = d_in;
   assign bus8.phi2 = phi2;
   assign bus8.a    = a;
   assign bus8.rw   = rw;
   assign bus8.d_in = d_in;

   k6502_bus_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WAIT_STATES(0)) u0 (
      .ph0(ph0), .reset_n(reset_n), .bus(bus0));
   k6502_bus_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WAIT_STATES(3)) u3 (
      .ph0(ph0), .reset_n(reset_n), .bus(bus3));
   k6502_bus_responder #(.BASE_ADDR(16'h0800), .ADDR_BITS(11), .WAIT_STATES(5)) u8 (
      .ph0(ph0), .reset_n(reset_n), .bus(bus8));

   initial ph0 = 1'b0;
   always #5 ph0 = ~ph0;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge ph0);
      #1;
   endtask

   task automatic set_bus(input logic p, input logic [15:0] ad, input logic r, input logic [7:0] d);
      phi2 = p;
      a    = ad;
      rw   = r;
      d_in = d;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_cycle(input logic [15:0] ad, input logic [7:0] d);
      set_bus(1'b1, ad, 1'b0, d);
      tick();
      phi2 = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      set_bus(1'b0, 16'h0000, 1'b1, 8'h00);
      tick();
      tick();
      chk("rst_d_oe",    16'(bus0.d_oe), 16'h0);
      chk("rst_rdy",     16'(bus0.rdy), 16'h1);
      chk("rst_sel",     16'(bus0.sel), 16'h0);
      chk("rst_overrun", 16'(bus0.overrun), 16'h0);
      chk("rst_d_out",   16'(bus0.d_out), 16'h00);
      chk("rst_rdy_ws5", 16'(bus8.rdy), 16'h1);
      reset_n = 1'b1;
      tick();

      // write A5 at 0123, then read it back with no wait states
      set_bus(1'b1, 16'h0123, 1'b0, 8'hA5);
      tick();
      chk("t2_wr_sel",  16'(bus0.sel), 16'h1);
      chk("t2_wr_d_oe", 16'(bus0.d_oe), 16'h0);
      phi2 = 1'b0;
      tick();
      chk("t2_wr_sel_clr", 16'(bus0.sel), 16'h0);
      tick();
      set_bus(1'b1, 16'h0123, 1'b1, 8'h00);
      tick();
      chk("t2_rd_n_rdy",  16'(bus0.rdy), 16'h1);
      chk("t2_rd_n_d_oe", 16'(bus0.d_oe), 16'h0);
      chk("t2_rd_n_sel",  16'(bus0.sel), 16'h1);
      tick();
      chk("t2_rd_n1_d_oe",  16'(bus0.d_oe), 16'h1);
      chk("t2_rd_n1_d_out", 16'(bus0.d_out), 16'hA5);
      chk("t2_rd_n1_rdy",   16'(bus0.rdy), 16'h1);
      tick();
      chk("t2_rd_hold_d_oe", 16'(bus0.d_oe), 16'h1);
      phi2 = 1'b0;
      tick();
      chk("t2_fall_d_oe",    16'(bus0.d_oe), 16'h0);
      chk("t2_fall_sel",     16'(bus0.sel), 16'h0);
      chk("t2_ws3_overrun",  16'(bus3.overrun), 16'h1);
      chk("t2_ws3_d_oe",     16'(bus3.d_oe), 16'h0);
      tick();
      chk("t2_ws3_overrun_pulse", 16'(bus3.overrun), 16'h0);

      // reset held for three edges while driving
      set_bus(1'b1, 16'h0123, 1'b1, 8'h00);
      tick();
      tick();
      chk("t1_drive_d_oe", 16'(bus0.d_oe), 16'h1);
      reset_n = 1'b0;
      tick();
      chk("t1_rst_d_oe", 16'(bus0.d_oe), 16'h0);
      chk("t1_rst_rdy",  16'(bus0.rdy), 16'h1);
      chk("t1_rst_sel",  16'(bus0.sel), 16'h0);
      tick();
      tick();
      chk("t1_rst3_d_oe", 16'(bus0.d_oe), 16'h0);
      reset_n = 1'b1;
      phi2 = 1'b0;
      tick();
      chk("t1_post_d_oe", 16'(bus0.d_oe), 16'h0);
      chk("t1_post_sel",  16'(bus0.sel), 16'h0);
      tick();

      // three wait states at the top of the base-0 window
      write_cycle(16'h07FF, 8'h3C);
      set_bus(1'b1, 16'h07FF, 1'b1, 8'h00);
      tick();
      chk("t3_n_rdy", 16'(bus3.rdy), 16'h0);
      tick();
      chk("t3_n1_rdy",  16'(bus3.rdy), 16'h0);
      chk("t3_n1_d_oe", 16'(bus3.d_oe), 16'h0);
      tick();
      chk("t3_n2_rdy", 16'(bus3.rdy), 16'h0);
      tick();
      chk("t3_n3_rdy",  16'(bus3.rdy), 16'h1);
      chk("t3_n3_d_oe", 16'(bus3.d_oe), 16'h0);
      tick();
      chk("t3_n4_d_oe",  16'(bus3.d_oe), 16'h1);
      chk("t3_n4_d_out", 16'(bus3.d_out), 16'h3C);
      chk("t3_ws0_d_out", 16'(bus0.d_out), 16'h3C);
      chk("t3_ws5_sel",  16'(bus8.sel), 16'h0);
      phi2 = 1'b0;
      tick();
      chk("t3_fall_d_oe",    16'(bus3.d_oe), 16'h0);
      chk("t3_fall_overrun", 16'(bus3.overrun), 16'h0);
      tick();

      // reset during a write must drop the write
      write_cycle(16'h0200, 8'h5A);
      set_bus(1'b1, 16'h0200, 1'b0, 8'hFF);
      tick();
      chk("t6_wr_sel", 16'(bus0.sel), 16'h1);
      reset_n = 1'b0;
      phi2 = 1'b0;
      tick();
      chk("t6_rst_sel",  16'(bus0.sel), 16'h0);
      chk("t6_rst_d_oe", 16'(bus0.d_oe), 16'h0);
      reset_n = 1'b1;
      tick();
      set_bus(1'b1, 16'h0200, 1'b1, 8'h00);
      tick();
      tick();
      chk("t6_rd_d_oe",  16'(bus0.d_oe), 16'h1);
      chk("t6_rd_d_out", 16'(bus0.d_out), 16'h5A);
      phi2 = 1'b0;
      tick();
      tick();

      // decode around a window based at 0800
      set_bus(1'b1, 16'h0800, 1'b0, 8'h77);
      tick();
      chk("t4_base_sel",     16'(bus8.sel), 16'h1);
      chk("t4_base_ws0_sel", 16'(bus0.sel), 16'h0);
      phi2 = 1'b0;
      tick();
      tick();
      set_bus(1'b1, 16'h0FFF, 1'b0, 8'h22);
      tick();
      chk("t4_top_sel", 16'(bus8.sel), 16'h1);
      phi2 = 1'b0;
      tick();
      tick();
      set_bus(1'b1, 16'h07FF, 1'b0, 8'h11);
      tick();
      chk("t4_below_sel",  16'(bus8.sel), 16'h0);
      chk("t4_below_d_oe", 16'(bus8.d_oe), 16'h0);
      phi2 = 1'b0;
      tick();
      chk("t4_below_fall_d_oe", 16'(bus8.d_oe), 16'h0);
      tick();
      set_bus(1'b1, 16'h1000, 1'b0, 8'h11);
      tick();
      chk("t4_above_sel",  16'(bus8.sel), 16'h0);
      chk("t4_above_d_oe", 16'(bus8.d_oe), 16'h0);
      phi2 = 1'b0;
      tick();
      tick();
      set_bus(1'b1, 16'h0FFF, 1'b1, 8'h00);
      tick();
      chk("t4_top_rd_rdy", 16'(bus8.rdy), 16'h0);
      repeat (5) tick();
      chk("t4_top_rd_n5_d_oe", 16'(bus8.d_oe), 16'h0);
      chk("t4_top_rd_n5_rdy",  16'(bus8.rdy), 16'h1);
      tick();
      chk("t4_top_rd_d_oe",  16'(bus8.d_oe), 16'h1);
      chk("t4_top_rd_d_out", 16'(bus8.d_out), 16'h22);
      phi2 = 1'b0;
      tick();
      tick();

      // phi2 drops two cycles into a five-wait read
      set_bus(1'b1, 16'h0900, 1'b1, 8'h00);
      tick();
      tick();
      tick();
      phi2 = 1'b0;
      tick();
      chk("t5_overrun",      16'(bus8.overrun), 16'h1);
      chk("t5_overrun_d_oe", 16'(bus8.d_oe), 16'h0);
      chk("t5_overrun_rdy",  16'(bus8.rdy), 16'h1);
      chk("t5_overrun_sel",  16'(bus8.sel), 16'h0);
      tick();
      chk("t5_overrun_pulse", 16'(bus8.overrun), 16'h0);
      set_bus(1'b1, 16'h0800, 1'b1, 8'h00);
      tick();
      repeat (5) tick();
      chk("t5_next_n5_d_oe", 16'(bus8.d_oe), 16'h0);
      tick();
      chk("t5_next_d_oe",  16'(bus8.d_oe), 16'h1);
      chk("t5_next_d_out", 16'(bus8.d_out), 16'h77);
      phi2 = 1'b0;
      tick();
      chk("t5_next_fall_d_oe", 16'(bus8.d_oe), 16'h0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
